morse_text_top: RTL and testbench

- Morse-code text entry with an 8-digit, multiplexed, common-anode 7-segment display.
- Pre-debounced buttons enter dots and dashes; an end-of-letter button decodes the accumulated code into a character and appends it to an 8-character text buffer.
- A clear button empties the text buffer; a backspace button deletes the last character.
- Board-level top of the Morse translator; button debouncing is upstream.

---
 rtl/morse_pkg.sv | 104 ++++++++++
 rtl/morse_text_top_seg_scan.sv | 36 +++
 rtl/morse_text_top.sv | 102 ++++++++++
 tb/tb_morse_text_top.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: char codes, button events, Morse decode and 7-segment font shared by the translator.
package morse_pkg;

    localparam int NSLOTS = 8;
    localparam int SYM_W  = 5;

    typedef enum logic [5:0] {
        CH_EMPTY, CH_A, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I,
        CH_J, CH_K, CH_L, CH_M, CH_N, CH_O, CH_P, CH_Q, CH_R, CH_S,
        CH_T, CH_U, CH_V, CH_W, CH_X, CH_Y, CH_Z, CH_0, CH_1, CH_2,
        CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9
    } char_t;

    typedef enum logic [2:0] {
        EV_NONE, EV_DOT, EV_DASH, EV_COMMIT, EV_BSP, EV_CLEAR
    } event_t;

    // bits hold the last len symbols, oldest symbol in the highest used bit; dash = 1
    function automatic logic [5:0] decode(input logic [2:0] len, input logic [4:0] bits);
        case ({len, bits})
            {3'd2, 5'b00001}: return CH_A;
            {3'd4, 5'b01000}: return CH_B;
            {3'd4, 5'b01010}: return CH_C;
            {3'd3, 5'b00100}: return CH_D;
            {3'd1, 5'b00000}: return CH_E;
            {3'd4, 5'b00010}: return CH_F;
            {3'd3, 5'b00110}: return CH_G;
            {3'd4, 5'b00000}: return CH_H;
            {3'd2, 5'b00000}: return CH_I;
            {3'd4, 5'b00111}: return CH_J;
            {3'd3, 5'b00101}: return CH_K;
            {3'd4, 5'b00100}: return CH_L;
            {3'd2, 5'b00011}: return CH_M;
            {3'd2, 5'b00010}: return CH_N;
            {3'd3, 5'b00111}: return CH_O;
            {3'd4, 5'b00110}: return CH_P;
            {3'd4, 5'b01101}: return CH_Q;
            {3'd3, 5'b00010}: return CH_R;
            {3'd3, 5'b00000}: return CH_S;
            {3'd1, 5'b00001}: return CH_T;
            {3'd3, 5'b00001}: return CH_U;
            {3'd4, 5'b00001}: return CH_V;
            {3'd3, 5'b00011}: return CH_W;
            {3'd4, 5'b01001}: return CH_X;
            {3'd4, 5'b01011}: return CH_Y;
            {3'd4, 5'b01100}: return CH_Z;
            {3'd5, 5'b11111}: return CH_0;
            {3'd5, 5'b01111}: return CH_1;
            {3'd5, 5'b00111}: return CH_2;
            {3'd5, 5'b00011}: return CH_3;
            {3'd5, 5'b00001}: return CH_4;
            {3'd5, 5'b00000}: return CH_5;
            {3'd5, 5'b10000}: return CH_6;
            {3'd5, 5'b11000}: return CH_7;
            {3'd5, 5'b11100}: return CH_8;
            {3'd5, 5'b11110}: return CH_9;
            default:          return CH_EMPTY;
        endcase
    endfunction

    // active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] font(input logic [5:0] ch);
        case (ch)
            CH_A: return 7'h08;
            CH_B: return 7'h60;
            CH_C: return 7'h31;
            CH_D: return 7'h42;
            CH_E: return 7'h30;
            CH_F: return 7'h38;
            CH_G: return 7'h21;
            CH_H: return 7'h48;
            CH_I: return 7'h79;
            CH_J: return 7'h43;
            CH_K: return 7'h28;
            CH_L: return 7'h71;
            CH_M: return 7'h2B;
            CH_N: return 7'h6A;
            CH_O: return 7'h01;
            CH_P: return 7'h18;
            CH_Q: return 7'h0C;
            CH_R: return 7'h7A;
            CH_S: return 7'h24;
            CH_T: return 7'h70;
            CH_U: return 7'h41;
            CH_V: return 7'h63;
            CH_W: return 7'h55;
            CH_X: return 7'h36;
            CH_Y: return 7'h44;
            CH_Z: return 7'h12;
            CH_0: return 7'h01;
            CH_1: return 7'h4F;
            CH_2: return 7'h12;
            CH_3: return 7'h06;
            CH_4: return 7'h4C;
            CH_5: return 7'h24;
            CH_6: return 7'h20;
            CH_7: return 7'h0F;
            CH_8: return 7'h00;
            CH_9: return 7'h04;
            default: return 7'h7F;
        endcase
    endfunction

endpackage

// File: rtl/morse_text_top_seg_scan.sv
// seg_scan: refresh divider and digit index driving an 8-digit common-anode multiplexed display.
module seg_scan
    import morse_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NSLOTS-1:0][5:0] text,
    output logic [7:0]             anode,
    output logic [6:0]             out
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic          last;

    assign last = (div == DW'(REFRESH_DIV - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            idx <= '0;
        end else begin
            div <= last ? '0 : div + 1'b1;
            idx <= last ? idx + 3'd1 : idx;
        end
    end

    // slot 0 sits on the leftmost digit, driven by anode[7]
    assign anode = ~(8'h80 >> idx);
    assign out   = font(text[idx]);

endmodule

// File: rtl/morse_text_top.sv
// morse_text_top: Morse text entry; buttons build a symbol code, commit decodes it into an
// 8-character buffer shown on a multiplexed 7-segment display.
module morse_text_top
    import morse_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_SYMBOLS = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       btn3,
    input  logic       btn4,
    input  logic       btn5,
    output logic [7:0] anode,
    output logic [6:0] out
);

    logic [2:0]             sym_len, sym_len_n;
    logic [SYM_W-1:0]       sym_bits, sym_bits_n;
    logic [NSLOTS-1:0][5:0] text, text_n;
    logic [3:0]             count, count_n;
    logic [5:0]             code;
    event_t                 ev;

    assign ev = btn4 ? EV_CLEAR  :
                btn5 ? EV_BSP    :
                btn3 ? EV_COMMIT :
                btn2 ? EV_DASH   :
                btn1 ? EV_DOT    : EV_NONE;

    assign code = decode(sym_len, sym_bits);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sym_len  <= '0;
            sym_bits <= '0;
            text     <= '0;
            count    <= '0;
        end else begin
            sym_len  <= sym_len_n;
            sym_bits <= sym_bits_n;
            text     <= text_n;
            count    <= count_n;
        end
    end

    always_comb begin
        sym_len_n  = sym_len;
        sym_bits_n = sym_bits;
        text_n     = text;
        count_n    = count;
        case (ev)
            EV_CLEAR: begin
                sym_len_n  = '0;
                sym_bits_n = '0;
                text_n     = '0;
                count_n    = '0;
            end
            EV_BSP: begin
                sym_len_n  = '0;
                sym_bits_n = '0;
                if (count != 4'd0) begin
                    text_n[count[2:0] - 3'd1] = CH_EMPTY;
                    count_n                   = count - 4'd1;
                end
            end
            EV_COMMIT: begin
                sym_len_n  = '0;
                sym_bits_n = '0;
                // a full buffer restarts with the new letter alone at the left
                if (code != CH_EMPTY) begin
                    if (count == 4'd8) begin
                        text_n    = '0;
                        text_n[0] = code;
                        count_n   = 4'd1;
                    end else begin
                        text_n[count[2:0]] = code;
                        count_n            = count + 4'd1;
                    end
                end
            end
            EV_DOT, EV_DASH: begin
                if (sym_len < 3'(MAX_SYMBOLS)) begin
                    sym_bits_n = {sym_bits[SYM_W-2:0], ev == EV_DASH};
                    sym_len_n  = sym_len + 3'd1;
                end
            end
            default: ;
        endcase
    end

    seg_scan #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .text    (text),
        .anode   (anode),
        .out     (out)
    );

endmodule

// File: tb/tb_morse_text_top.sv
// tb_morse_text_top: directed and random button traffic checked against a string-based Morse model.
module tb_morse_text_top;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0, btn4 = 1'b0, btn5 = 1'b0;
    logic [7:0] anode;
    logic [6:0] out;

    int tests = 0;
    int fails = 0;

    string morse[36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };
    logic [6:0] font_m[37] = '{
        7'h7F,
        7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38, 7'h21, 7'h48, 7'h79, 7'h43,
        7'h28, 7'h71, 7'h2B, 7'h6A, 7'h01, 7'h18, 7'h0C, 7'h7A, 7'h24, 7'h70,
        7'h41, 7'h63, 7'h55, 7'h36, 7'h44, 7'h12,
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
    };

    string      sym_m;
    int         slot_m[8];
    int         cnt_m;
    logic [2:0] idx_m;

    morse_text_top #(.REFRESH_DIV(1), .MAX_SYMBOLS(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .btn1    (btn1),
        .btn2    (btn2),
        .btn3    (btn3),
        .btn4    (btn4),
        .btn5    (btn5),
        .anode   (anode),
        .out     (out)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int decode_m(input string s);
        for (int i = 0; i < 36; i++)
            if (s == morse[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        sym_m = "";
        cnt_m = 0;
        idx_m = 3'd0;
        for (int i = 0; i < 8; i++) slot_m[i] = 0;
    endtask

    // b = {btn5, btn4, btn3, btn2, btn1}
    task automatic model_apply(input logic [4:0] b);
        int c;
        if (b[3]) begin
            model_reset_text();
            sym_m = "";
        end else if (b[4]) begin
            sym_m = "";
            if (cnt_m > 0) begin
                cnt_m--;
                slot_m[cnt_m] = 0;
            end
        end else if (b[2]) begin
            c = decode_m(sym_m);
            sym_m = "";
            if (c != 0) begin
                if (cnt_m == 8) begin
                    model_reset_text();
                    slot_m[0] = c;
                    cnt_m = 1;
                end else begin
                    slot_m[cnt_m] = c;
                    cnt_m++;
                end
            end
        end else if (b[1] || b[0]) begin
            if (sym_m.len() < 5) sym_m = {sym_m, b[1] ? "-" : "."};
        end
    endtask

    task automatic model_reset_text();
        cnt_m = 0;
        for (int i = 0; i < 8; i++) slot_m[i] = 0;
    endtask

    task automatic step(input logic [4:0] b);
        {btn5, btn4, btn3, btn2, btn1} = b;
        @(posedge clock);
        model_apply(b);
        idx_m = idx_m + 3'd1;
        #1;
        check("anode", anode, ~(8'h80 >> idx_m));
        check("segments", {1'b0, out}, {1'b0, font_m[slot_m[idx_m]]});
        @(negedge clock);
        {btn5, btn4, btn3, btn2, btn1} = 5'b0;
    endtask

    task automatic enter(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i] == "-" ? 5'b00010 : 5'b00001);
        step(5'b00100);
    endtask

    task automatic scan_expect(input string tag, input logic [2:0] slot, input logic [6:0] exp);
        for (int k = 0; k < 8 && idx_m != slot; k++) step(5'b0);
        check(tag, {1'b0, out}, {1'b0, exp});
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_anode", anode, 8'h7F);
        check("reset_out", {1'b0, out}, 8'h7F);
        reset_n = 1'b1;
        repeat (8) step(5'b0);

        enter(".-");
        scan_expect("slot0_A", 3'd0, 7'h08);
        enter("-...");
        scan_expect("slot1_B", 3'd1, 7'h60);

        step(5'b01000);
        for (int i = 0; i < 8; i++) enter(morse[i]);
        scan_expect("slot4_E", 3'd4, 7'h30);
        scan_expect("slot7_H", 3'd7, 7'h48);
        scan_expect("slot2_C", 3'd2, 7'h31);
        scan_expect("slot0_A_full", 3'd0, 7'h08);

        enter("....");
        scan_expect("overflow_slot0", 3'd0, 7'h48);
        scan_expect("overflow_slot1", 3'd1, 7'h7F);
        scan_expect("overflow_slot7", 3'd7, 7'h7F);

        step(5'b10000);
        repeat (8) step(5'b0);
        scan_expect("bsp_slot0", 3'd0, 7'h7F);
        step(5'b10000);
        enter(".");
        scan_expect("bsp_at_zero", 3'd0, 7'h30);

        step(5'b01000);
        step(5'b00001);
        step(5'b00101);
        step(5'b00100);
        scan_expect("commit_over_dot", 3'd0, 7'h30);
        scan_expect("commit_only_once", 3'd1, 7'h7F);

        step(5'b01000);
        repeat (6) step(5'b00001);
        step(5'b00100);
        scan_expect("six_dots_5", 3'd0, 7'h24);

        enter(".-.-.");
        scan_expect("invalid_no_append", 3'd1, 7'h7F);

        step(5'b00010);
        step(5'b00001);
        step(5'b01000);
        step(5'b00100);
        scan_expect("clear_mid_letter", 3'd0, 7'h7F);

        enter("-.-.");
        repeat (3) step(5'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_anode", anode, 8'h7F);
        check("async_reset_out", {1'b0, out}, 8'h7F);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (8) step(5'b0);

        for (int n = 0; n < 500; n++) begin
            logic [4:0] b;
            b[0] = $urandom_range(0, 99) < 40;
            b[1] = $urandom_range(0, 99) < 30;
            b[2] = $urandom_range(0, 99) < 20;
            b[3] = $urandom_range(0, 99) < 2;
            b[4] = $urandom_range(0, 99) < 4;
            step(b);
        end
        repeat (8) step(5'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
